// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: pixel stage behind the VGA timing generator.
// Two-stage pipeline producing bars, checker, bouncing box and gradient.
module vga_pattern_gen #(
  parameter int WIDTH       = 640,
  parameter int HEIGHT      = 480,
  parameter int BOX_SIZE    = 32,
  parameter int STEP        = 2,
  parameter int CHECK_SHIFT = 5
) (
  input  logic        px_clk,
  input  logic        rst,
  input  logic [13:0] hpos,
  input  logic [13:0] vpos,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        enable,
  input  logic [1:0]  mode,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        de_out,
  output logic [15:0] frame_cnt
);

  localparam int          BAR_W  = WIDTH / 8;
  localparam logic [13:0] BOX_L  = 14'(BOX_SIZE);
  localparam logic [13:0] STEP_L = 14'(STEP);
  localparam logic [13:0] W_L    = 14'(WIDTH);
  localparam logic [13:0] H_L    = 14'(HEIGHT);
  localparam logic [13:0] X_MAX  = 14'(WIDTH - BOX_SIZE);
  localparam logic [13:0] Y_MAX  = 14'(HEIGHT - BOX_SIZE);

  logic [13:0] hpos_q, hpos_d, vpos_q, vpos_d;
  logic        hs1_q, hs1_d, vs1_q, vs1_d, en1_q, en1_d;
  logic        vprev_q, vprev_d;
  logic [1:0]  mode_q, mode_d;
  logic [13:0] bx_q, bx_d, by_q, by_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [11:0] rgb_q, rgb_d;
  logic        hs2_q, hs2_d, vs2_q, vs2_d, de2_q, de2_d;

  logic        frame_ev;
  logic [11:0] bars;
  logic [11:0] pat;
  logic        in_box;

  // Colour of the sample held in stage 1, from the pre-event state.
  always_comb begin
    bars = 12'h000;
    if (hpos_q < 14'(BAR_W))
      bars = 12'hFFF;
    else if (hpos_q < 14'(2 * BAR_W))
      bars = 12'hFF0;
    else if (hpos_q < 14'(3 * BAR_W))
      bars = 12'h0FF;
    else if (hpos_q < 14'(4 * BAR_W))
      bars = 12'h0F0;
    else if (hpos_q < 14'(5 * BAR_W))
      bars = 12'hF0F;
    else if (hpos_q < 14'(6 * BAR_W))
      bars = 12'hF00;
    else if (hpos_q < 14'(7 * BAR_W))
      bars = 12'h00F;
    in_box = (hpos_q >= bx_q) && (hpos_q < bx_q + BOX_L) &&
             (vpos_q >= by_q) && (vpos_q < by_q + BOX_L);
    case (mode_q)
      2'd0: pat = bars;
      2'd1: pat = (hpos_q[CHECK_SHIFT] ^ vpos_q[CHECK_SHIFT]) ?
                  12'hFFF : 12'h000;
      2'd2: pat = in_box ? 12'hF00 : 12'h004;
      default: pat = {hpos_q[7:4], vpos_q[7:4], frame_cnt_q[3:0]};
    endcase
  end

  // Next state: input capture, frame-boundary updates, output stage.
  always_comb begin
    hpos_d      = hpos;
    vpos_d      = vpos;
    hs1_d       = hsync;
    vs1_d       = vsync;
    en1_d       = enable;
    vprev_d     = vs1_q;
    mode_d      = mode_q;
    bx_d        = bx_q;
    by_d        = by_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    frame_cnt_d = frame_cnt_q;
    rgb_d       = en1_q ? pat : 12'h000;
    hs2_d       = hs1_q;
    vs2_d       = vs1_q;
    de2_d       = en1_q;
    frame_ev    = vprev_q & ~vs1_q;
    if (frame_ev) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
      mode_d      = mode;
      if (dx_q) begin
        if (bx_q + STEP_L + BOX_L >= W_L) begin
          bx_d = X_MAX;
          dx_d = 1'b0;
        end else begin
          bx_d = bx_q + STEP_L;
        end
      end else begin
        if (bx_q <= STEP_L) begin
          bx_d = 14'd0;
          dx_d = 1'b1;
        end else begin
          bx_d = bx_q - STEP_L;
        end
      end
      if (dy_q) begin
        if (by_q + STEP_L + BOX_L >= H_L) begin
          by_d = Y_MAX;
          dy_d = 1'b0;
        end else begin
          by_d = by_q + STEP_L;
        end
      end else begin
        if (by_q <= STEP_L) begin
          by_d = 14'd0;
          dy_d = 1'b1;
        end else begin
          by_d = by_q - STEP_L;
        end
      end
    end
  end

  // State registers; reset drives everything to the idle/blank values.
  always_ff @(posedge px_clk or posedge rst) begin
    if (rst) begin
      hpos_q      <= '0;
      vpos_q      <= '0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      en1_q       <= 1'b0;
      vprev_q     <= 1'b1;
      mode_q      <= 2'd0;
      bx_q        <= '0;
      by_q        <= '0;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      frame_cnt_q <= '0;
      rgb_q       <= '0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      de2_q       <= 1'b0;
    end else begin
      hpos_q      <= hpos_d;
      vpos_q      <= vpos_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      en1_q       <= en1_d;
      vprev_q     <= vprev_d;
      mode_q      <= mode_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      frame_cnt_q <= frame_cnt_d;
      rgb_q       <= rgb_d;
      hs2_q       <= hs2_d;
      vs2_q       <= vs2_d;
      de2_q       <= de2_d;
    end
  end

  assign red       = rgb_q[11:8];
  assign green     = rgb_q[7:4];
  assign blue      = rgb_q[3:0];
  assign hsync_out = hs2_q;
  assign vsync_out = vs2_q;
  assign de_out    = de2_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: sample-level reference model checked every
// cycle, plus hand-computed pixel expectations at chosen points.
module tb_vga_pattern_gen;

  logic        px_clk = 1'b0;
  logic        rst = 1'b1;
  logic [13:0] hpos = '0;
  logic [13:0] vpos = '0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [3:0]  red, green, blue;
  logic        hsync_out, vsync_out, de_out;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit scan_on = 1'b0;

  vga_pattern_gen dut (
    .px_clk(px_clk), .rst(rst), .hpos(hpos), .vpos(vpos),
    .hsync(hsync), .vsync(vsync), .enable(enable), .mode(mode),
    .red(red), .green(green), .blue(blue),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .de_out(de_out),
    .frame_cnt(frame_cnt)
  );

  always #5 px_clk = ~px_clk;

  // Reference model state
  int m_mode, m_bx, m_by, m_dx, m_dy, m_fc, m_max_bx;
  bit m_vprev;
  int p_h, p_v;
  bit p_hs, p_vs, p_en, p_sc;
  logic [11:0] e_rgb;
  bit e_hs, e_vs, e_de, e_sc;
  int e_h;

  function automatic logic [11:0] colour(int h, int v, bit en);
    int bar;
    if (!en) return 12'h000;
    case (m_mode)
      0: begin
        bar = h / 80;
        if (bar > 7) bar = 7;
        case (bar)
          0: return 12'hFFF;
          1: return 12'hFF0;
          2: return 12'h0FF;
          3: return 12'h0F0;
          4: return 12'hF0F;
          5: return 12'hF00;
          6: return 12'h00F;
          default: return 12'h000;
        endcase
      end
      1: return (((h / 32) + (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
      2: return (h >= m_bx && h < m_bx + 32 && v >= m_by && v < m_by + 32)
                ? 12'hF00 : 12'h004;
      default: return {4'((h / 16) % 16), 4'((v / 16) % 16), 4'(m_fc % 16)};
    endcase
  endfunction

  task automatic move(inout int pos, inout int dir, input int lim);
    if (dir > 0) begin
      if (pos + 2 + 32 >= lim) begin
        pos = lim - 32;
        dir = -1;
      end else pos = pos + 2;
    end else begin
      if (pos <= 2) begin
        pos = 0;
        dir = 1;
      end else pos = pos - 2;
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_bx = 0; m_by = 0; m_dx = 1; m_dy = 1; m_fc = 0;
    m_vprev = 1;
    p_h = 0; p_v = 0; p_hs = 1; p_vs = 1; p_en = 0; p_sc = 0;
    e_rgb = 12'h000; e_hs = 1; e_vs = 1; e_de = 0; e_sc = 0; e_h = 0;
  endtask

  // Model: one input sample per edge, emitted one edge after capture.
  initial begin
    m_max_bx = 0;
    model_reset();
    forever begin
      @(posedge px_clk or posedge rst);
      if (rst) model_reset();
      else begin
        e_rgb = colour(p_h, p_v, p_en);
        e_hs = p_hs; e_vs = p_vs; e_de = p_en; e_sc = p_sc; e_h = p_h;
        if (m_vprev && !p_vs) begin
          m_fc = (m_fc + 1) % 65536;
          m_mode = int'(mode);
          move(m_bx, m_dx, 640);
          move(m_by, m_dy, 480);
          if (m_bx > m_max_bx) m_max_bx = m_bx;
        end
        m_vprev = p_vs;
        p_h = int'(hpos); p_v = int'(vpos);
        p_hs = hsync; p_vs = vsync; p_en = enable; p_sc = scan_on;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin
    bit want;
    forever begin
      @(negedge px_clk);
      cyc++;
      total++;
      if ({red, green, blue} !== e_rgb || hsync_out !== e_hs ||
          vsync_out !== e_vs || de_out !== e_de ||
          frame_cnt !== 16'(m_fc)) begin
        bad++;
        $display("FAIL model cyc=%0d got rgb=%h hs=%b vs=%b de=%b fc=%h want rgb=%h hs=%b vs=%b de=%b fc=%h",
                 cyc, {red, green, blue}, hsync_out, vsync_out, de_out,
                 frame_cnt, e_rgb, e_hs, e_vs, e_de, 16'(m_fc));
      end
      if (e_sc) begin
        total++;
        want = !(e_h >= 656 && e_h < 752);
        if (hsync_out !== want) begin
          bad++;
          $display("FAIL hsync_pos h=%0d got=%b want=%b", e_h, hsync_out, want);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  task automatic probe(input int h, input int v, input bit en,
                       input logic [11:0] want, input string nm);
    @(negedge px_clk);
    hpos = 14'(h); vpos = 14'(v); enable = en; hsync = 1; vsync = 1;
    @(posedge px_clk);
    @(posedge px_clk);
    @(negedge px_clk);
    #1;
    chk(nm, 32'({red, green, blue}), 32'(want));
    enable = 0;
  endtask

  task automatic scan_line(input int v, input int h0, input int h1);
    for (int h = h0; h < h1; h++) begin
      @(negedge px_clk);
      scan_on = 1;
      hpos = 14'(h); vpos = 14'(v);
      enable = (h < 640);
      hsync = !(h >= 656 && h < 752);
      vsync = 1;
    end
    @(negedge px_clk);
    scan_on = 0; enable = 0; hsync = 1; hpos = 0;
  endtask

  task automatic vblank();
    for (int i = 0; i < 5; i++) begin
      @(negedge px_clk);
      enable = 0; hsync = 1; hpos = 0; vpos = 0;
      vsync = (i >= 3);
    end
  endtask

  task automatic fast_frames(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge px_clk);
      vsync = 0; enable = 1;
      hpos = 14'(m_bx + 32); vpos = 14'(m_by);
      @(negedge px_clk);
      vsync = 1;
      hpos = 14'(m_bx); vpos = 14'(m_by);
    end
    @(negedge px_clk);
    enable = 0; vsync = 1;
  endtask

  task automatic rst_pulse_mid_cycle();
    #2 rst = 1;
    #1;
    chk("rst_rgb", 32'({red, green, blue}), 32'h0);
    chk("rst_hs", 32'(hsync_out), 32'h1);
    chk("rst_vs", 32'(vsync_out), 32'h1);
    chk("rst_de", 32'(de_out), 32'h0);
    chk("rst_fc", 32'(frame_cnt), 32'h0);
  endtask

  initial begin
    // Power-on reset
    repeat (2) @(negedge px_clk);
    chk("por_rgb", 32'({red, green, blue}), 32'h0);
    chk("por_de", 32'(de_out), 32'h0);
    chk("por_hs", 32'(hsync_out), 32'h1);
    // First sample after release shows two edges later
    @(negedge px_clk);
    rst = 0;
    hpos = 0; vpos = 0; enable = 1;
    @(posedge px_clk);
    @(negedge px_clk);
    chk("rel_1cyc_de", 32'(de_out), 32'h0);
    @(posedge px_clk);
    @(negedge px_clk);
    #1;
    chk("rel_first_px", 32'({red, green, blue}), 32'hFFF);
    enable = 0;

    // Colour bars
    vblank();
    scan_line(0, 0, 800);
    probe(0, 0, 1, 12'hFFF, "bar0");
    probe(79, 0, 1, 12'hFFF, "bar0_end");
    probe(80, 0, 1, 12'hFF0, "bar1");
    probe(160, 0, 1, 12'h0FF, "bar2");
    probe(240, 0, 1, 12'h0F0, "bar3");
    probe(320, 0, 1, 12'hF0F, "bar4");
    probe(400, 0, 1, 12'hF00, "bar5");
    probe(480, 0, 1, 12'h00F, "bar6");
    probe(639, 0, 1, 12'h000, "bar7");
    probe(100, 0, 0, 12'h000, "blank");

    // Reset in the middle of a line
    scan_line(1, 0, 300);
    rst_pulse_mid_cycle();
    @(negedge px_clk);
    rst = 0;
    hpos = 80; vpos = 5; enable = 1;
    @(posedge px_clk);
    @(posedge px_clk);
    @(negedge px_clk);
    #1;
    chk("rst_first_px", 32'({red, green, blue}), 32'hFF0);
    enable = 0;

    // Mode change mid-frame waits for the next frame event
    vblank();
    scan_line(99, 0, 800);
    mode = 2'd1;
    scan_line(100, 0, 800);
    probe(32, 100, 1, 12'hFFF, "mode_hold");
    vblank();
    probe(31, 0, 1, 12'h000, "chk_31_0");
    probe(32, 0, 1, 12'hFFF, "chk_32_0");
    probe(32, 32, 1, 12'h000, "chk_32_32");
    probe(32, 100, 1, 12'h000, "chk_32_100");

    // Gradient and frame counter wrap
    mode = 2'd3;
    vblank();
    chk("fc_3", 32'(frame_cnt), 32'd3);
    probe(53, 71, 1, 12'h343, "grad_fc3");
    @(negedge px_clk);
    #2;
    force dut.frame_cnt_q = 16'hFFFF;
    m_fc = 65535;
    @(posedge px_clk);
    #1;
    release dut.frame_cnt_q;
    probe(53, 71, 1, 12'h34F, "grad_fcffff");
    chk("fc_ffff", 32'(frame_cnt), 32'hFFFF);
    vblank();
    chk("fc_wrap", 32'(frame_cnt), 32'h0);
    probe(53, 71, 1, 12'h340, "grad_fc0");

    // Bouncing box from a clean reset
    @(negedge px_clk);
    rst_pulse_mid_cycle();
    mode = 2'd2;
    @(negedge px_clk);
    rst = 0;
    fast_frames(304);
    chk("fc_304", 32'(frame_cnt), 32'd304);
    chk("model_bx608", 32'(m_bx), 32'd608);
    chk("model_by288", 32'(m_by), 32'd288);
    probe(608, 288, 1, 12'hF00, "box_tl");
    probe(607, 288, 1, 12'h004, "box_left");
    probe(639, 319, 1, 12'hF00, "box_br");
    probe(640, 288, 1, 12'h004, "box_right");
    probe(608, 320, 1, 12'h004, "box_below");
    fast_frames(16);
    chk("model_bx576", 32'(m_bx), 32'd576);
    chk("model_by256", 32'(m_by), 32'd256);
    chk("model_bxmax", 32'(m_max_bx), 32'd608);
    probe(576, 256, 1, 12'hF00, "box2_tl");
    probe(575, 256, 1, 12'h004, "box2_left");
    probe(608, 256, 1, 12'h004, "box2_right");

    repeat (3) @(negedge px_clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
- Pixel-stage consumer of the VGA timing generator: takes hpos/vpos/hsync/vsync/enable on px_clk and produces 12-bit RGB, plus sync and data-enable delayed to match.
- Provides four test patterns for bring-up: colour bars, checkerboard, bouncing box and gradient.
- Pattern selection and box animation update only at frame boundaries, so no frame ever shows a partial (torn) update.

Parameters:
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines per frame.
- BOX_SIZE, 32, bouncing-box edge length in pixels.
- STEP, 2, box movement per frame in pixels, on each axis.
- CHECK_SHIFT, 5, checker cell size is 2^CHECK_SHIFT pixels.

Ports:
- px_clk  in  1  pixel clock; all state is clocked on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- hpos  in  14  horizontal position from the timing generator.
- vpos  in  14  vertical position from the timing generator.
- hsync  in  1  horizontal sync in, active-low.
- vsync  in  1  vertical sync in, active-low.
- enable  in  1  active-video flag.
- mode  in  2  requested pattern: 0 bars, 1 checker, 2 box, 3 gradient.
- red, green, blue  out  4 each  pixel colour.
- hsync_out  out  1  hsync delayed by 2 cycles.
- vsync_out  out  1  vsync delayed by 2 cycles.
- de_out  out  1  enable delayed by 2 cycles.
- frame_cnt  out  16  count of frames started.

Behaviour:
- Reset (async, rst=1):
  - red/green/blue = 0; hsync_out = 1; vsync_out = 1; de_out = 0; frame_cnt = 0.
  - Internal pipeline registers are cleared to the same idle values.
  - Latched mode (cur_mode) = 0; box bx = 0, by = 0; dx = +1, dy = +1; vsync_prev = 1.
  - If rst asserts mid-frame, outputs go idle immediately. After release, the first output sample appears 2 cycles later.
- Pipeline: fixed 2-cycle latency.
  - Stage 1 registers the inputs and computes the colour.
  - Stage 2 registers the RGB, syncs and de_out.
  - An input sample at edge N appears on the outputs after edge N+2.
- Blanking: when the delayed enable is 0, RGB = 0 regardless of mode.
- Frame event: vsync falling edge (vsync_prev=1, vsync=0), detected in stage 1. On that edge:
  - frame_cnt increments, wrapping 0xFFFF -> 0.
  - cur_mode <= mode.
  - The box position updates.
  - mode changes at any other time have no visible effect until the next frame event.
- Box update, x axis (y is identical with by, dy, HEIGHT):
  - dx=+1 and bx+STEP+BOX_SIZE >= WIDTH: bx <= WIDTH-BOX_SIZE, dx <= -1.
  - dx=+1 otherwise: bx <= bx+STEP.
  - dx=-1 and bx <= STEP: bx <= 0, dx <= +1.
  - dx=-1 otherwise: bx <= bx-STEP.
  - Position registers are 14-bit unsigned and never underflow.
- Patterns (computed from the registered hpos/vpos, as {r,g,b}):
  - Mode 0: bar = hpos/(WIDTH/8), implemented with constant comparisons (no divider). Bars 0..7 are white, yellow, cyan, green, magenta, red, blue, black (each channel F or 0).
  - Mode 1: white (FFF) if hpos[CHECK_SHIFT] ^ vpos[CHECK_SHIFT], else black (000).
  - Mode 2: red F00 if bx <= hpos < bx+BOX_SIZE and by <= vpos < by+BOX_SIZE, else 004.
  - Mode 3: r = hpos[7:4], g = vpos[7:4], b = frame_cnt[3:0].
- Simultaneous events: a frame event on the same edge as a sample uses the old cur_mode and box position for that sample. The new values apply from the next edge.
- hpos/vpos values outside the active area are don't-care; they are blanked by enable.

Test Plan:
- Reset pulse mid-line -> same cycle: RGB=0, hsync_out=1, vsync_out=1, de_out=0, frame_cnt=0. First valid pixel 2 cycles after release.
- Mode 0 with timing generator driven, capture line 0 -> RGB FFF for px 0-79, FF0 for 80-159, … 000 for 560-639; 000 in blanking; hsync_out low exactly on delayed positions 656-751.
- Mode 1 -> pixel (31,0)=000, (32,0)=FFF, (32,32)=000.
- Change mode 0->1 at line 100 -> bars continue to end of frame; checker starts at frame start after vsync falls.
- Mode 2 over 320 frames (run as 320 simulated frames, or force bx near the edge):
  - bx reaches 608 then reverses; bx never >608 or <0.
  - Pixel (bx,by)=F00, (bx+32,by)=004.
- frame_cnt forced to 0xFFFF, one vsync falling edge -> 0x0000. Mode 3 blue channel follows frame_cnt[3:0].
